// File: rtl/out_sender_arb_if.sv
// Byte-stream requesters and UART pin bundle for the shared transmitter.
// Two valid/ready byte streams in, serial line and busy flag out.
interface out_sender_arb_if;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       dbg_valid;
    logic [7:0] dbg_data;
    logic       dbg_ready;
    logic       txd;
    logic       busy;

    modport master (
        output out_valid, out_data, dbg_valid, dbg_data,
        input  out_ready, dbg_ready, txd, busy
    );

    modport slave (
        input  out_valid, out_data, dbg_valid, dbg_data,
        output out_ready, dbg_ready, txd, busy
    );
endinterface

// File: rtl/out_sender_arb.sv
// Shared 8N1 UART transmitter with round-robin arbitration
// between the commit-path and debug-path byte streams.
module out_sender_arb #(
    parameter int CLK_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             rst,
    out_sender_arb_if.slave  bus
);
    localparam int CW = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0] CMAX = CW'(CLK_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          txd_q, txd_d;
    logic          last_q, last_d;

    logic          idle;
    logic          gnt_o, gnt_d;
    logic          xfer_o, xfer_d;
    logic          wrap;
    logic [CW-1:0] cnt_nx;

    // last_q high means the debug path won the previous transfer
    assign idle   = (state_q == IDLE) && !rst;
    assign gnt_o  = bus.out_valid && (!bus.dbg_valid || last_q);
    assign gnt_d  = bus.dbg_valid && (!bus.out_valid || !last_q);
    assign xfer_o = idle && gnt_o;
    assign xfer_d = idle && gnt_d;

    assign bus.out_ready = xfer_o;
    assign bus.dbg_ready = xfer_d;
    assign bus.txd       = txd_q;
    assign bus.busy      = (state_q != IDLE);

    assign wrap   = (cnt_q == CMAX);
    assign cnt_nx = wrap ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (xfer_o || xfer_d) begin
                    state_d = START;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sh_d    = xfer_o ? bus.out_data : bus.dbg_data;
                    txd_d   = 1'b0;
                    last_d  = xfer_d;
                end
            end
            START: begin
                cnt_d = cnt_nx;
                if (wrap) begin
                    state_d = DATA;
                    txd_d   = sh_q[0];
                end
            end
            DATA: begin
                cnt_d = cnt_nx;
                if (wrap) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = sh_q[bit_d];
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_nx;
                if (wrap) begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
            last_q  <= last_d;
        end
    end
endmodule
